// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: instruction memory with an autonomous sequential fetch
// PC, a registered array read, and a QDEPTH-entry prefetch FIFO drained by
// decode through a valid/ready handshake. Redirects flush the queue and
// restart fetch at a new address.
// Optional feature macro: IMEM_LOAD_EN enables the run-time program-load
// write port. Without it the array is a ROM and the load_* ports are ignored.
module imem_fetch_queue #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 7,
  parameter int          QDEPTH    = 4,
  parameter int unsigned RESET_PC  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic                        clka,
  input  logic                        rsta_n,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_addr,
  output logic                        fetch_valid,
  input  logic                        fetch_ready,
  output logic [DATA_W-1:0]           fetch_instr,
  output logic [ADDR_W-1:0]           fetch_addr,
  input  logic                        load_we,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [DATA_W-1:0]           load_data,
  output logic [$clog2(QDEPTH):0]     q_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage
  logic [DATA_W-1:0] r_mem     [DEPTH];
  logic [DATA_W-1:0] r_q_instr [QDEPTH];
  logic [ADDR_W-1:0] r_q_addr  [QDEPTH];

  // Fetch / read pipeline state
  logic [ADDR_W-1:0] r_pc;
  logic              r_rd_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;

  // Queue bookkeeping
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  // Registered head outputs
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;

  // Combinational control
  logic              w_pop;
  logic              w_push;
  logic [CNT_W:0]    w_occ;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [CNT_W-1:0]  w_next_count;
  logic [CNT_W-1:0]  w_cnt_after_pop;
  logic [PTR_W-1:0]  w_rptr_next;
  logic              w_next_valid;
  logic [DATA_W-1:0] w_next_instr;
  logic [ADDR_W-1:0] w_next_addr;

  // Handshake, issue decision and queue occupancy arithmetic.
  always_comb begin
    w_pop           = r_out_valid & fetch_ready;
    // A redirect discards whatever read is in flight, so nothing is pushed.
    w_push          = r_rd_valid & ~redirect_valid;
    // pop <= count always holds, so this never underflows.
    w_occ           = {1'b0, r_count} + (CNT_W+1)'(r_rd_valid) - (CNT_W+1)'(w_pop);
    w_cnt_after_pop = r_count - CNT_W'(w_pop);
    w_rptr_next     = r_rptr + PTR_W'(w_pop);
    if (redirect_valid) begin
      w_issue      = 1'b1;
      w_issue_addr = redirect_addr;
      w_next_count = '0;
    end else begin
      w_issue      = (w_occ < (CNT_W+1)'(QDEPTH));
      w_issue_addr = r_pc;
      w_next_count = w_cnt_after_pop + CNT_W'(w_push);
    end
  end

  // Next queue head: surviving old entry first, else the word being pushed.
  always_comb begin
    w_next_valid = 1'b0;
    w_next_instr = '0;
    w_next_addr  = '0;
    if (redirect_valid) begin
      w_next_valid = 1'b0;
    end else if (w_cnt_after_pop != '0) begin
      w_next_valid = 1'b1;
      w_next_instr = r_q_instr[w_rptr_next];
      w_next_addr  = r_q_addr[w_rptr_next];
    end else if (w_push) begin
      w_next_valid = 1'b1;
      w_next_instr = r_rd_data;
      w_next_addr  = r_rd_addr;
    end else begin
      w_next_valid = 1'b0;
    end
  end

  // Array write port (read-first) and registered read of the issuing address.
  always_ff @(posedge clka) begin
`ifdef IMEM_LOAD_EN
    if (rsta_n && load_we) begin
      r_mem[load_addr] <= load_data;
    end
`endif
    r_rd_data <= r_mem[w_issue_addr];
  end

`ifndef IMEM_LOAD_EN
  // Load port is present but has no effect in the read-only build.
  logic w_load_unused;
  assign w_load_unused = load_we ^ (^load_addr) ^ (^load_data);
`endif

  // Fetch PC and in-flight read tag.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      r_pc       <= ADDR_W'(RESET_PC);
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) begin
        r_rd_addr <= w_issue_addr;
        r_pc      <= w_issue_addr + ADDR_W'(1);
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      r_rptr  <= w_rptr_next;
      r_count <= w_next_count;
    end
  end

  // Queue entry storage, written at the tail on a push.
  always_ff @(posedge clka) begin
    if (rsta_n && w_push) begin
      r_q_instr[r_wptr] <= r_rd_data;
      r_q_addr[r_wptr]  <= r_rd_addr;
    end
  end

  // Registered head outputs; zero whenever the queue is empty.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
    end else begin
      r_out_valid <= w_next_valid;
      r_out_instr <= w_next_instr;
      r_out_addr  <= w_next_addr;
    end
  end

  assign fetch_valid = r_out_valid;
  assign fetch_instr = r_out_instr;
  assign fetch_addr  = r_out_addr;
  assign q_count     = r_count;

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Self-checking bench for imem_fetch_queue: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_imem_fetch_queue;

  localparam int DEPTH = 128;
  localparam int QD    = 4;

  logic        clka = 1'b0;
  logic        rsta_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [6:0]  redirect_addr = 7'd0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [6:0]  fetch_addr;
  logic        load_we = 1'b0;
  logic [6:0]  load_addr = 7'd0;
  logic [31:0] load_data = 32'd0;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  imem_fetch_queue #(
    .DATA_W(32), .ADDR_W(7), .QDEPTH(QD), .RESET_PC(0), .INIT_FILE("")
  ) dut (
    .clka(clka), .rsta_n(rsta_n),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_addr(fetch_addr),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .q_count(q_count)
  );

  always #5 clka = ~clka;

  // Reference model: memory image, FIFO of fetched words, one pending read.
  typedef struct { int unsigned addr; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_infl = 0;
  ent_t        m_infl_ent;
  int unsigned m_pc = 0;

  logic        e_valid;
  logic [6:0]  e_addr;
  logic [31:0] e_instr;
  logic [2:0]  e_count;

  task automatic model_step();
    bit pop;
    int occ;
    if (!rsta_n) begin
      mq.delete();
      m_infl = 0;
      m_pc   = 0;
    end else begin
      if (redirect_valid) begin
        mq.delete();
        m_infl          = 1;
        m_infl_ent.addr = redirect_addr;
        m_infl_ent.data = m_mem[redirect_addr];
        m_pc            = (redirect_addr + 1) % DEPTH;
      end else begin
        pop = (mq.size() > 0) && fetch_ready;
        occ = mq.size() + int'(m_infl) - int'(pop);
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_ent);
        if (occ < QD) begin
          m_infl          = 1;
          m_infl_ent.addr = m_pc;
          m_infl_ent.data = m_mem[m_pc];
          m_pc            = (m_pc + 1) % DEPTH;
        end else begin
          m_infl = 0;
        end
      end
`ifdef IMEM_LOAD_EN
      if (load_we) m_mem[load_addr] = load_data;
`endif
    end
  endtask

  task automatic model_outputs();
    e_count = 3'(mq.size());
    if (mq.size() > 0) begin
      e_valid = 1'b1;
      e_addr  = 7'(mq[0].addr);
      e_instr = mq[0].data;
    end else begin
      e_valid = 1'b0;
      e_addr  = 7'd0;
      e_instr = 32'd0;
    end
  endtask

  // Advance model and DUT by one edge; outputs are examined 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge clka);
    #1;
    model_outputs();
  endtask

  task automatic test_reset();
    rsta_n = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; load_we = 1'b0;
    tick(); tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr, q_count} !== {1'b0, 7'd0, 32'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b a=%h i=%h c=%0d, expected all zero",
               fetch_valid, fetch_addr, fetch_instr, q_count);
    end
    rsta_n = 1'b1;
    tick();
    n_checks++;
    if (fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch_e0: got valid=%0b expected 0", fetch_valid);
    end
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'd0, 32'h100}) begin
      n_fail++;
      $display("FAIL first_fetch_e1: got v=%0b a=%h i=%h expected v=1 a=00 i=00000100",
               fetch_valid, fetch_addr, fetch_instr);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'(i + 1), 32'(i + 'h101)}) begin
        n_fail++;
        $display("FAIL stream_seq %0d: got v=%0b a=%h i=%h expected a=%h i=%h",
                 i, fetch_valid, fetch_addr, fetch_instr, 7'(i + 1), 32'(i + 'h101));
      end
    end
  endtask

  task automatic test_backpressure();
    rsta_n = 1'b0; fetch_ready = 1'b0;
    tick();
    rsta_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({fetch_valid, fetch_addr, fetch_instr, q_count} !== {e_valid, e_addr, e_instr, e_count}) begin
        n_fail++;
        $display("FAIL bp_model cyc %0d: got v=%0b a=%h i=%h c=%0d expected v=%0b a=%h i=%h c=%0d",
                 i, fetch_valid, fetch_addr, fetch_instr, q_count, e_valid, e_addr, e_instr, e_count);
      end
    end
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr, q_count} !== {1'b1, 7'd0, 32'h100, 3'd4}) begin
      n_fail++;
      $display("FAIL bp_saturate: got v=%0b a=%h i=%h c=%0d expected v=1 a=00 i=00000100 c=4",
               fetch_valid, fetch_addr, fetch_instr, q_count);
    end
    fetch_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({fetch_valid, fetch_addr} !== {1'b1, 7'(i + 1)}) begin
        n_fail++;
        $display("FAIL bp_drain %0d: got v=%0b a=%h expected v=1 a=%h",
                 i, fetch_valid, fetch_addr, 7'(i + 1));
      end
    end
  endtask

  task automatic test_redirect();
    fetch_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 7'h40;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({fetch_valid, q_count} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL redirect_bubble: got v=%0b c=%0d expected v=0 c=0", fetch_valid, q_count);
    end
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'h40, 32'h140}) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%0b a=%h i=%h expected v=1 a=40 i=00000140",
               fetch_valid, fetch_addr, fetch_instr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'(i + 'h41), 32'(i + 'h141)}) begin
        n_fail++;
        $display("FAIL redirect_follow %0d: got v=%0b a=%h i=%h expected a=%h",
                 i, fetch_valid, fetch_addr, fetch_instr, 7'(i + 'h41));
      end
    end
  endtask

  task automatic test_back_to_back();
    fetch_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 7'h20;
    tick();
    redirect_addr = 7'h30;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_bubble: got v=%0b expected 0", fetch_valid);
    end
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'h30, 32'h130}) begin
      n_fail++;
      $display("FAIL b2b_last_wins: got v=%0b a=%h i=%h expected v=1 a=30 i=00000130",
               fetch_valid, fetch_addr, fetch_instr);
    end
  endtask

  task automatic test_wrap();
    logic [6:0] exp_a;
    fetch_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 7'h7E;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_a = 7'((126 + i) % 128);
      n_checks++;
      if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, exp_a, 32'h100 + 32'(exp_a)}) begin
        n_fail++;
        $display("FAIL wrap %0d: got v=%0b a=%h i=%h expected a=%h",
                 i, fetch_valid, fetch_addr, fetch_instr, exp_a);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] exp_new;
`ifdef IMEM_LOAD_EN
    exp_new = 32'hDEADBEEF;
`else
    exp_new = 32'h110;
`endif
    fetch_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 7'h10;
    load_we = 1'b1; load_addr = 7'h10; load_data = 32'hDEADBEEF;
    tick();
    redirect_valid = 1'b0; load_we = 1'b0;
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'h10, 32'h110}) begin
      n_fail++;
      $display("FAIL load_read_first: got v=%0b a=%h i=%h expected v=1 a=10 i=00000110",
               fetch_valid, fetch_addr, fetch_instr);
    end
    tick(); tick();
    redirect_valid = 1'b1; redirect_addr = 7'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'h10, exp_new}) begin
      n_fail++;
      $display("FAIL load_new_word: got v=%0b a=%h i=%h expected v=1 a=10 i=%h",
               fetch_valid, fetch_addr, fetch_instr, exp_new);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = 7'($urandom_range(0, 127));
      load_we        = ($urandom_range(0, 7) == 0);
      load_addr      = 7'($urandom_range(0, 127));
      load_data      = $urandom;
      tick();
      n_checks++;
      if ({fetch_valid, fetch_addr, fetch_instr, q_count} !== {e_valid, e_addr, e_instr, e_count}) begin
        n_fail++;
        $display("FAIL rand_model cyc %0d: got v=%0b a=%h i=%h c=%0d expected v=%0b a=%h i=%h c=%0d",
                 i, fetch_valid, fetch_addr, fetch_instr, q_count, e_valid, e_addr, e_instr, e_count);
      end
    end
    redirect_valid = 1'b0; load_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    fetch_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (q_count !== 3'd4) begin
      n_fail++;
      $display("FAIL rstmid_full: got c=%0d expected 4", q_count);
    end
    rsta_n = 1'b0; redirect_valid = 1'b1; redirect_addr = 7'h55; fetch_ready = 1'b1;
    load_we = 1'b1; load_addr = 7'h05; load_data = 32'h12345678;
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr, q_count} !== {1'b0, 7'd0, 32'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL rstmid_zero: got v=%0b a=%h i=%h c=%0d expected all zero",
               fetch_valid, fetch_addr, fetch_instr, q_count);
    end
    rsta_n = 1'b1; redirect_valid = 1'b0; load_we = 1'b0;
    tick();
    n_checks++;
    if (fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_e0: got v=%0b expected 0", fetch_valid);
    end
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {1'b1, 7'd0, e_instr}) begin
      n_fail++;
      $display("FAIL rstmid_restart: got v=%0b a=%h i=%h expected v=1 a=00 i=%h",
               fetch_valid, fetch_addr, fetch_instr, e_instr);
    end
    redirect_valid = 1'b1; redirect_addr = 7'h05;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if ({fetch_valid, fetch_addr, fetch_instr} !== {e_valid, e_addr, e_instr} || e_addr !== 7'h05) begin
      n_fail++;
      $display("FAIL rstmid_load_ignored: got v=%0b a=%h i=%h expected v=%0b a=05 i=%h",
               fetch_valid, fetch_addr, fetch_instr, e_valid, e_instr);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]     = 32'(i + 'h100);
      dut.r_mem[i] = 32'(i + 'h100);
    end
    test_reset();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_load();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
